arbitro_agua: RTL
=================

ARBITRO_AGUA -- requirements
Module: arbitro_agua

Interface
REQ-001 The block SHALL have parameter TEMPO_MAX, default 16, meaning the maximum fill cycles per grant before timeout (legal range 2..255).
REQ-002 The block SHALL have parameter PAUSA_CICLOS, default 2, meaning the idle cycles between consecutive grants (legal range 1..15).
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port pedido  input  4  per-machine water request, bit i = washing machine i.
REQ-006 The block SHALL have port cheio  input  4  per-machine tank-full level sensor.
REQ-007 The block SHALL have port erro_limpa  input  4  per-machine error clear strobe.
REQ-008 The block SHALL have port concede  output  4  one-hot grant of the shared water inlet, all-zero when idle.
REQ-009 The block SHALL have port valvula_agua  output  1  shared inlet valve drive.
REQ-010 The block SHALL have port ocupado  output  1  high in any state other than LIVRE.
REQ-011 The block SHALL have port erro  output  4  sticky per-machine fill-timeout flag.

Function
REQ-012 The block SHALL implement states LIVRE, ENCHENDO and PAUSA; all outputs SHALL be registered.
REQ-013 In LIVRE with pedido nonzero, the block SHALL select the first requesting index at or after pointer ptr (wrap 3->0), assert that concede bit and valvula_agua on the next cycle, clear the fill counter and enter ENCHENDO.
REQ-014 In LIVRE with pedido zero, the block SHALL remain in LIVRE with concede=0, valvula_agua=0.
REQ-015 In ENCHENDO the fill counter (8 bits) SHALL increment once per cycle; concede and valvula_agua SHALL stay constant.
REQ-016 ENCHENDO SHALL end when cheio[g]=1 or pedido[g]=0 for granted index g (or on timeout per REQ-027); the next cycle SHALL have concede=0, valvula_agua=0, state PAUSA, ptr=(g+1) mod 4.
REQ-017 Changes on non-granted pedido/cheio bits during ENCHENDO SHALL be ignored.
REQ-018 PAUSA SHALL last exactly PAUSA_CICLOS cycles, then LIVRE; requests during PAUSA SHALL be held off, not lost (level-sensitive).
REQ-019 If cheio[g] and timeout occur in the same cycle, cheio SHALL win and erro[g] SHALL not be set.
REQ-020 erro_limpa[i]=1 SHALL clear erro[i] on the next edge; if set and clear coincide for the same bit, set SHALL win.
REQ-021 A requester with erro[i]=1 SHALL still be eligible for grants.
REQ-022 Worst-case wait for any continuously requesting machine SHALL be bounded by 3 grants of other machines (round-robin fairness).

Reset
REQ-023 On rst=1 at a rising edge the block SHALL enter LIVRE with ptr=0, fill counter=0, concede=0, valvula_agua=0, ocupado=0, erro=0.
REQ-024 rst SHALL take priority over all other inputs, including mid-ENCHENDO, closing the valve on the next cycle.
REQ-025 rst SHALL have no effect between clock edges.

Configuration
REQ-026 The macro ARBITRO_AGUA_TIMEOUT_EN SHALL compile the fill timeout in or out.
REQ-027 With ARBITRO_AGUA_TIMEOUT_EN defined, reaching counter=TEMPO_MAX-1 in ENCHENDO without cheio[g] SHALL end the grant as in REQ-016 and set erro[g].
REQ-028 Without ARBITRO_AGUA_TIMEOUT_EN, no timeout SHALL exist, grants end only on cheio or withdrawal, and erro SHALL be constant 0.

Verification
REQ-029 Reset then pedido=4'b0101 held -> concede=0001 one cycle after, cheio[0]=1 after 5 cycles -> concede=0, PAUSA 2 cycles, then concede=0100.
REQ-030 pedido=4'b1111 held, each machine asserts cheio after 3 grant cycles -> concede sequence 0001,0010,0100,1000,0001 separated by 2-cycle gaps.
REQ-031 TIMEOUT_EN, TEMPO_MAX=16, pedido=0010, cheio=0 -> concede=0010 for exactly 16 cycles, then erro=0010; erro_limpa=0010 -> erro=0000 next cycle.
REQ-032 TIMEOUT_EN, cheio[g] asserted on the timeout cycle -> grant ends, erro stays 0000.
REQ-033 rst=1 mid-ENCHENDO with concede=1000 -> next cycle concede=0, valvula_agua=0, ocupado=0, and next grant for pedido=1001 goes to 0001 (ptr=0).
REQ-034 Granted machine drops pedido after 4 cycles -> grant ends next cycle, no erro, ptr advances.

Source files
------------

// File: rtl/arbitro_agua.sv
// Round-robin arbiter sharing one water inlet among four washing machines.
// Define ARBITRO_AGUA_TIMEOUT_EN to compile in the fill timeout and sticky erro flags.
module arbitro_agua #(
  parameter int unsigned TEMPO_MAX    = 16,
  parameter int unsigned PAUSA_CICLOS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pedido,
  input  logic [3:0] cheio,
  input  logic [3:0] erro_limpa,
  output logic [3:0] concede,
  output logic       valvula_agua,
  output logic       ocupado,
  output logic [3:0] erro
);

  localparam logic [7:0] TempoLim = 8'(TEMPO_MAX - 1);
  localparam logic [3:0] PausaLim = 4'(PAUSA_CICLOS - 1);

  typedef enum logic [1:0] {StLivre, StEnchendo, StPausa} estado_e;

  estado_e    estado_q, estado_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] g_q, g_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic [3:0] concede_q, concede_d;
  logic       valvula_q, valvula_d;
  logic       ocupado_q, ocupado_d;
  logic [3:0] erro_q, erro_d;

  logic [1:0] sel;
  logic [1:0] idx;
  logic       inicia;
  logic       timeout_hit;

  // Descending scan so the requester closest to ptr (smallest offset) wins.
  always_comb begin
    sel = ptr_q;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (pedido[idx]) sel = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= StLivre;
      ptr_q     <= '0;
      g_q       <= '0;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      concede_q <= '0;
      valvula_q <= 1'b0;
      ocupado_q <= 1'b0;
      erro_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      concede_q <= concede_d;
      valvula_q <= valvula_d;
      ocupado_q <= ocupado_d;
      erro_q    <= erro_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    pcnt_d      = pcnt_q;
    inicia      = 1'b0;
    timeout_hit = 1'b0;
    unique case (estado_q)
      StLivre: inicia = |pedido;
      StEnchendo: begin
        cnt_d = cnt_q + 8'd1;
`ifdef ARBITRO_AGUA_TIMEOUT_EN
        timeout_hit = (cnt_q == TempoLim) && !cheio[g_q];
`endif
        if (cheio[g_q] || !pedido[g_q] || timeout_hit) begin
          estado_d = StPausa;
          ptr_d    = g_q + 2'd1;
          pcnt_d   = '0;
        end
      end
      StPausa: begin
        // The last pause cycle arbitrates like LIVRE so the concede gap is exactly PAUSA_CICLOS.
        if (pcnt_q == PausaLim) begin
          estado_d = StLivre;
          inicia   = |pedido;
        end else begin
          pcnt_d = pcnt_q + 4'd1;
        end
      end
      default: estado_d = StLivre;
    endcase
    if (inicia) begin
      estado_d = StEnchendo;
      g_d      = sel;
      cnt_d    = '0;
    end
  end

  always_comb begin
    concede_d = (estado_d == StEnchendo) ? (4'b0001 << g_d) : 4'b0000;
    valvula_d = (estado_d == StEnchendo);
    ocupado_d = (estado_d != StLivre);
`ifdef ARBITRO_AGUA_TIMEOUT_EN
    erro_d = erro_q & ~erro_limpa;
    if (timeout_hit) erro_d[g_q] = 1'b1;
`else
    erro_d = '0;
`endif
  end

  logic unused_cfg;
  assign unused_cfg = ^{erro_limpa, TempoLim, timeout_hit, erro_q};

  assign concede      = concede_q;
  assign valvula_agua = valvula_q;
  assign ocupado      = ocupado_q;
  assign erro         = erro_q;

endmodule
